nf2_dma_tx_packer: RTL

- Downstream neighbour of the DMA queue interface on the CPU transmit path.
- Accepts per-queue 32-bit DMA words (data plus one-hot EOP ctrl), which upstream always pads to a multiple of USER_DATA_PATH_WIDTH/DMA_DATA_WIDTH words.
- Packs each group of lanes into one 64-bit user-datapath word with 8-bit ctrl and buffers it in a small fall-through FIFO.
- Presents the packed words on a NetFPGA-style out_wr/out_rdy interface toward the CPU tx queue datapath.
- One instance per CPU queue.

---
 rtl/nf2_dma_tx_packer_pkg.sv | 23 ++
 rtl/dma_pack_fifo.sv | 69 ++++++
 rtl/nf2_dma_tx_packer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/nf2_dma_tx_packer_pkg.sv
// ============================================================================
// Module  : nf2_dma_tx_packer_pkg
// Brief   : Lane-placement helpers shared by the DMA tx packer and rx unpacker.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nf2_dma_tx_packer_pkg;

    localparam int DEFAULT_NEARLY_FULL_MARGIN = 2;

    function automatic int lane_ratio(input int user_w, input int dma_w);
        return user_w / dma_w;
    endfunction

    // A lane index needs at least one bit even when there is a single lane.
    function automatic int lane_idx_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dma_pack_fifo.sv
// ============================================================================
// Module  : dma_pack_fifo
// Brief   : Synchronous fall-through FIFO; dout always shows the head entry.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dma_pack_fifo #(
    parameter int WIDTH      = 72,
    parameter int DEPTH_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WIDTH-1:0]      din,
    input  logic                  wr_en,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_BITS:0]   count
);

    localparam logic [DEPTH_BITS:0] c_full_count = (DEPTH_BITS+1)'(1 << DEPTH_BITS);

    logic [WIDTH-1:0]      r_mem [0:(1<<DEPTH_BITS)-1];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_full_count);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign w_do_rd = rd_en && !empty;
    assign w_do_wr = wr_en && (!full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nf2_dma_tx_packer.sv
// ============================================================================
// Module  : nf2_dma_tx_packer
// Brief   : Packs DMA lane words into user-datapath words behind a small FIFO.
//           Define NF2_DMA_TX_PACKER_STATS_EN to build packet/word counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nf2_dma_tx_packer
    import nf2_dma_tx_packer_pkg::*;
#(
    parameter int DMA_DATA_WIDTH       = 32,
    parameter int DMA_CTRL_WIDTH       = DMA_DATA_WIDTH / 8,
    parameter int USER_DATA_PATH_WIDTH = 64,
    parameter int CTRL_WIDTH           = USER_DATA_PATH_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS      = 4,
    parameter int NEARLY_FULL_MARGIN   = DEFAULT_NEARLY_FULL_MARGIN
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            cpu_q_dma_wr,
    input  logic [DMA_DATA_WIDTH-1:0]       cpu_q_dma_wr_data,
    input  logic [DMA_CTRL_WIDTH-1:0]       cpu_q_dma_wr_ctrl,
    output logic                            cpu_q_dma_nearly_full,
    output logic [USER_DATA_PATH_WIDTH-1:0] out_data,
    output logic [CTRL_WIDTH-1:0]           out_ctrl,
    output logic                            out_wr,
    input  logic                            out_rdy,
    output logic                            overflow_err,
    output logic [31:0]                     pkt_cnt,
    output logic [31:0]                     word_cnt
);

    localparam int c_ratio   = lane_ratio(USER_DATA_PATH_WIDTH, DMA_DATA_WIDTH);
    localparam int c_idx_w   = lane_idx_width(c_ratio);
    localparam int c_entry_w = CTRL_WIDTH + USER_DATA_PATH_WIDTH;
    localparam int c_cnt_w   = FIFO_DEPTH_BITS + 1;

    localparam logic [c_idx_w-1:0] c_last_lane = c_idx_w'(c_ratio - 1);
    localparam logic [c_cnt_w-1:0] c_depth     = c_cnt_w'(1 << FIFO_DEPTH_BITS);
    localparam logic [c_cnt_w-1:0] c_margin    = c_cnt_w'(NEARLY_FULL_MARGIN);

    logic [c_idx_w-1:0]              r_lane_idx;
    logic                            r_overflow;
    logic                            w_last_lane;
    logic                            w_push;
    logic [USER_DATA_PATH_WIDTH-1:0] w_pack_data;
    logic [CTRL_WIDTH-1:0]           w_pack_ctrl;
    logic [c_entry_w-1:0]            w_fifo_dout;
    logic                            w_fifo_empty;
    logic                            w_fifo_full;
    logic [c_cnt_w-1:0]              w_fifo_count;
    logic [c_cnt_w-1:0]              w_free;

    assign w_last_lane = (r_lane_idx == c_last_lane);
    assign w_push      = cpu_q_dma_wr && w_last_lane;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lane_idx <= '0;
        end else if (cpu_q_dma_wr) begin
            r_lane_idx <= w_last_lane ? '0 : r_lane_idx + 1'b1;
        end
    end

    // Lane 0 sits in the most-significant slot; the final lane bypasses the
    // hold registers so the whole group is pushed on the edge that accepts it.
    for (genvar k = 0; k < c_ratio - 1; k++) begin : g_hold_lane
        logic [DMA_DATA_WIDTH-1:0] r_data;
        logic [DMA_CTRL_WIDTH-1:0] r_ctrl;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data <= '0;
                r_ctrl <= '0;
            end else if (cpu_q_dma_wr && (r_lane_idx == c_idx_w'(k))) begin
                r_data <= cpu_q_dma_wr_data;
                r_ctrl <= cpu_q_dma_wr_ctrl;
            end
        end

        assign w_pack_data[DMA_DATA_WIDTH*(c_ratio-k)-1 -: DMA_DATA_WIDTH] = r_data;
        assign w_pack_ctrl[DMA_CTRL_WIDTH*(c_ratio-k)-1 -: DMA_CTRL_WIDTH] = r_ctrl;
    end

    assign w_pack_data[DMA_DATA_WIDTH-1:0] = cpu_q_dma_wr_data;
    assign w_pack_ctrl[DMA_CTRL_WIDTH-1:0] = cpu_q_dma_wr_ctrl;

    dma_pack_fifo #(
        .WIDTH      (c_entry_w),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .din   ({w_pack_ctrl, w_pack_data}),
        .wr_en (w_push),
        .rd_en (out_wr),
        .dout  (w_fifo_dout),
        .empty (w_fifo_empty),
        .full  (w_fifo_full),
        .count (w_fifo_count)
    );

    assign out_wr   = !w_fifo_empty && out_rdy;
    assign out_data = w_fifo_empty ? '0 : w_fifo_dout[USER_DATA_PATH_WIDTH-1:0];
    assign out_ctrl = w_fifo_empty ? '0 : w_fifo_dout[c_entry_w-1:USER_DATA_PATH_WIDTH];

    // The margin absorbs the upstream write already in flight plus its pad lanes.
    assign w_free                = c_depth - w_fifo_count;
    assign cpu_q_dma_nearly_full = (w_free <= c_margin);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_push && w_fifo_full && !out_wr) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_err = r_overflow;

`ifdef NF2_DMA_TX_PACKER_STATS_EN
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_word_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (out_wr) begin
            r_word_cnt <= r_word_cnt + 1'b1;
            if (out_ctrl != '0) begin
                r_pkt_cnt <= r_pkt_cnt + 1'b1;
            end
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign word_cnt = r_word_cnt;
`else
    assign pkt_cnt  = '0;
    assign word_cnt = '0;
`endif

endmodule

`default_nettype wire
